// File: rtl/pmci_vdm_tx_seq_if.sv
// PMCI VDM TX sequencer bus.
// Groups the host-side write/command signals and the packet stream toward the
// VDM TLP builder.
//   master : host/CSR side and stream sink (drives wr_*, cmd_*, err_clr, tx_ready)
//   slave  : the sequencer (drives tx_*, busy, done, fifo_cnt, err_*)
interface pmci_vdm_tx_seq_if #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 64,
    parameter int MAX_PLD_DW = 16,
    parameter int CW         = $clog2(FIFO_DEPTH) + 1,
    parameter int PW         = $clog2(MAX_PLD_DW) + 1
);
    // Host -> sequencer
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              cmd_valid;
    logic [CW-1:0]     cmd_len;
    logic              cmd_flush;
    logic              err_clr;
    // Packet stream
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_sop;
    logic              tx_eop;
    logic              tx_som;
    logic              tx_eom;
    logic [1:0]        tx_pkt_seq;
    logic [PW-1:0]     tx_pld_len;
    logic              tx_abort;
    // Status
    logic              busy;
    logic              done;
    logic [CW-1:0]     fifo_cnt;
    logic              err_ovf;
    logic              err_cmd;

    modport master (
        output wr_valid, wr_data, cmd_valid, cmd_len, cmd_flush, err_clr, tx_ready,
        input  tx_valid, tx_data, tx_sop, tx_eop, tx_som, tx_eom, tx_pkt_seq,
               tx_pld_len, tx_abort, busy, done, fifo_cnt, err_ovf, err_cmd
    );

    modport slave (
        input  wr_valid, wr_data, cmd_valid, cmd_len, cmd_flush, err_clr, tx_ready,
        output tx_valid, tx_data, tx_sop, tx_eop, tx_som, tx_eom, tx_pkt_seq,
               tx_pld_len, tx_abort, busy, done, fifo_cnt, err_ovf, err_cmd
    );
endinterface

// File: rtl/pmci_vdm_tx_seq.sv
// Host-side sequencer for PMCI PCIe VDM (MCTP) transmit.
// Host DWORD writes are queued in a first-word-fall-through FIFO; a commit of
// cmd_len DWORDs is cut into packets of at most MAX_PLD_DW DWORDs and streamed
// out with SOP/EOP, SOM/EOM and a 2-bit packet sequence number.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pmci_vdm_tx_seq_if.slave (host writes/commands, packet
//                stream, busy/done, fifo_cnt, sticky err_ovf/err_cmd)
module pmci_vdm_tx_seq #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 64,   // power of 2
    parameter int MAX_PLD_DW = 16    // must not exceed FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pmci_vdm_tx_seq_if.slave        bus
);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int PW    = $clog2(MAX_PLD_DW) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] MAX_REM  = CW'(MAX_PLD_DW);
    localparam logic [PW-1:0] MAX_PLD  = PW'(MAX_PLD_DW);

    typedef enum logic [1:0] {IDLE = 2'd0, PKT = 2'd1, SEND = 2'd2} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d, rem_q, rem_d;
    logic [PW-1:0]     pld_q, pld_d, beat_q, beat_d;
    logic              first_q, first_d, som_q, som_d, eom_q, eom_d;
    logic [1:0]        seq_q, seq_d;
    logic              done_q, done_d, abort_q, abort_d;
    logic              err_ovf_q, err_ovf_d, err_cmd_q, err_cmd_d;
    logic              sending, last_beat, full, pop, push, ovf_set, cmd_bad;

    assign sending   = (state_q == SEND);
    assign last_beat = (beat_q == pld_q - PW'(1));
    assign full      = (cnt_q == FULL_CNT);
    // Flush wins over everything: a beat presented in the flush cycle is
    // abandoned rather than consumed, and a same-cycle write is dropped.
    assign pop       = sending && bus.tx_ready && !bus.cmd_flush;
    assign push      = bus.wr_valid && !bus.cmd_flush && (!full || pop);
    assign ovf_set   = bus.wr_valid && !bus.cmd_flush && full && !pop;

    // FIFO pointer/count next state
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (bus.cmd_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    // NOTE: the storage array has no reset; only pointers/count define validity, and tx_data is gated by tx_valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.wr_data;
    end

    // Sequencer next state
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        first_d = first_q;
        pld_d   = pld_q;
        som_d   = som_q;
        eom_d   = eom_q;
        beat_d  = beat_q;
        seq_d   = seq_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        cmd_bad = 1'b0;
        if (bus.cmd_flush) begin
            state_d = IDLE;
            rem_d   = '0;
            abort_d = (state_q != IDLE);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        if (bus.cmd_len != '0 && bus.cmd_len <= cnt_q) begin
                            rem_d   = bus.cmd_len;
                            first_d = 1'b1;
                            state_d = PKT;
                        end else begin
                            cmd_bad = 1'b1;
                        end
                    end
                end
                PKT: begin
                    pld_d   = (rem_q > MAX_REM) ? MAX_PLD : rem_q[PW-1:0];
                    som_d   = first_q;
                    eom_d   = (rem_q <= MAX_REM);
                    beat_d  = '0;
                    state_d = SEND;
                end
                SEND: begin
                    if (bus.tx_ready) begin
                        beat_d = beat_q + PW'(1);
                        if (last_beat) begin
                            rem_d   = rem_q - CW'(pld_q);
                            seq_d   = seq_q + 2'd1;
                            first_d = 1'b0;
                            if (rem_q == CW'(pld_q)) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = PKT;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
            if (bus.cmd_valid && state_q != IDLE) cmd_bad = 1'b1;
        end
    end

    // A set event in the clear cycle keeps the flag high.
    assign err_ovf_d = ovf_set | (err_ovf_q & ~bus.err_clr);
    assign err_cmd_d = cmd_bad | (err_cmd_q & ~bus.err_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            rem_q     <= '0;
            pld_q     <= '0;
            beat_q    <= '0;
            first_q   <= 1'b0;
            som_q     <= 1'b0;
            eom_q     <= 1'b0;
            seq_q     <= 2'd0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            err_ovf_q <= 1'b0;
            err_cmd_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            pld_q     <= pld_d;
            beat_q    <= beat_d;
            first_q   <= first_d;
            som_q     <= som_d;
            eom_q     <= eom_d;
            seq_q     <= seq_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
            err_ovf_q <= err_ovf_d;
            err_cmd_q <= err_cmd_d;
        end
    end

    // Packet attributes are only meaningful while a beat is presented.
    assign bus.tx_valid   = sending;
    assign bus.tx_data    = sending ? mem_q[rd_ptr_q] : '0;
    assign bus.tx_sop     = sending && (beat_q == '0);
    assign bus.tx_eop     = sending && last_beat;
    assign bus.tx_som     = sending && som_q;
    assign bus.tx_eom     = sending && eom_q;
    assign bus.tx_pkt_seq = sending ? seq_q : 2'd0;
    assign bus.tx_pld_len = sending ? pld_q : '0;
    assign bus.tx_abort   = abort_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.fifo_cnt   = cnt_q;
    assign bus.err_ovf    = err_ovf_q;
    assign bus.err_cmd    = err_cmd_q;
endmodule

// File: tb/tb_pmci_vdm_tx_seq.sv
// Self-checking bench for pmci_vdm_tx_seq. A queue holds the expected FIFO
// contents; expected packets are derived from message length arithmetic.
module tb_pmci_vdm_tx_seq;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 64;
    localparam int MAX_PLD_DW = 16;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;
    localparam int PW         = $clog2(MAX_PLD_DW) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pmci_vdm_tx_seq_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .MAX_PLD_DW(MAX_PLD_DW)) bus ();

    pmci_vdm_tx_seq #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .MAX_PLD_DW(MAX_PLD_DW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] mq[$];   // expected FIFO contents, head first
    int exp_seq = 0;
    int done_seen = 0;
    bit exp_cmd = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid"}, bus.tx_valid, 0);
        check({tag, "_sop"},   bus.tx_sop, 0);
        check({tag, "_eop"},   bus.tx_eop, 0);
        check({tag, "_som"},   bus.tx_som, 0);
        check({tag, "_eom"},   bus.tx_eom, 0);
        check({tag, "_seq"},   bus.tx_pkt_seq, 0);
        check({tag, "_pld"},   bus.tx_pld_len, 0);
        check({tag, "_data"},  bus.tx_data, 0);
        check({tag, "_abort"}, bus.tx_abort, 0);
        check({tag, "_busy"},  bus.busy, 0);
        check({tag, "_done"},  bus.done, 0);
        check({tag, "_cnt"},   bus.fifo_cnt, 0);
        check({tag, "_ovf"},   bus.err_ovf, 0);
        check({tag, "_ecmd"},  bus.err_cmd, 0);
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        if (mq.size() < FIFO_DEPTH) mq.push_back(d);
        step();
        bus.wr_valid = 1'b0;
    endtask

    task automatic commit(input int len);
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = CW'(len);
        step();
        bus.cmd_valid = 1'b0;
    endtask

    // Follows a committed message from the cycle after commit. stop_pkt >= 0
    // interrupts packet stop_pkt on its 5th beat with a flush (or a reset).
    task automatic drain(input int len, input int pct, input bit busy_cmd,
                         input int stop_pkt, input bit stop_rst, input bit push_during);
        int npk, rem, pld, stall;
        bit rdy;
        logic [DATA_W-1:0] pd;
        npk = (len + MAX_PLD_DW - 1) / MAX_PLD_DW;
        rem = len;
        check("latency_gap", bus.tx_valid, 0);
        check("busy_set", bus.busy, 1);
        if (busy_cmd) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_len   = CW'(2);
        end
        step();
        bus.cmd_valid = 1'b0;
        if (busy_cmd) check("err_cmd_busy", bus.err_cmd, 1);
        for (int p = 0; p < npk; p++) begin
            pld = (rem > MAX_PLD_DW) ? MAX_PLD_DW : rem;
            if (p > 0) begin
                check("pkt_gap", bus.tx_valid, 0);
                step();
            end
            for (int b = 0; b < pld; b++) begin
                stall = 0;
                forever begin
                    check("valid", bus.tx_valid, 1);
                    check("sop", bus.tx_sop, (b == 0));
                    check("eop", bus.tx_eop, (b == pld - 1));
                    check("som", bus.tx_som, (p == 0));
                    check("eom", bus.tx_eom, (p == npk - 1));
                    check("seq", bus.tx_pkt_seq, exp_seq);
                    check("pld_len", bus.tx_pld_len, pld);
                    check("data", bus.tx_data, mq[0]);
                    check("fifo_cnt", bus.fifo_cnt, mq.size());
                    if (p == stop_pkt && b == 4) begin
                        if (!stop_rst) begin
                            bus.cmd_flush = 1'b1;
                            bus.wr_valid  = 1'b1;
                            bus.wr_data   = 32'hDEAD_BEEF;
                            step();
                            bus.cmd_flush = 1'b0;
                            bus.wr_valid  = 1'b0;
                            mq.delete();
                            check("flush_abort", bus.tx_abort, 1);
                            check("flush_valid", bus.tx_valid, 0);
                            check("flush_cnt", bus.fifo_cnt, 0);
                            check("flush_busy", bus.busy, 0);
                            check("flush_keeps_err", bus.err_cmd, exp_cmd);
                            step();
                            check("abort_pulse_end", bus.tx_abort, 0);
                            check("flush_wr_dropped", bus.fifo_cnt, 0);
                        end else begin
                            #2;
                            rst_n = 1'b0;
                            #1;
                            check_reset("midrst");
                            mq.delete();
                            exp_seq = 0;
                            exp_cmd = 1'b0;
                            @(negedge clk);
                            rst_n = 1'b1;
                            step();
                        end
                        return;
                    end
                    rdy = (stall >= 20) || ($urandom_range(99) < pct);
                    bus.tx_ready = rdy;
                    pd = $urandom;
                    if (push_during && rdy) begin
                        bus.wr_valid = 1'b1;
                        bus.wr_data  = pd;
                    end
                    step();
                    bus.wr_valid = 1'b0;
                    bus.tx_ready = 1'b0;
                    if (rdy) break;
                    stall++;
                end
                void'(mq.pop_front());
                // A push alongside a pop is always accepted, even at full.
                if (push_during) mq.push_back(pd);
            end
            rem -= pld;
            exp_seq = (exp_seq + 1) % 4;
        end
        check("done_pulse", bus.done, 1);
        check("busy_clear", bus.busy, 0);
        check("valid_after", bus.tx_valid, 0);
        if (bus.done === 1'b1) done_seen++;
        step();
        check("done_end", bus.done, 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        bus.cmd_flush = 1'b0;
        bus.err_clr   = 1'b0;
        bus.tx_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // 1: single full-size packet
        for (int i = 1; i <= 16; i++) push(DATA_W'(i));
        check("t1_cnt", bus.fifo_cnt, 16);
        commit(16);
        drain(16, 100, 1'b0, -1, 1'b0, 1'b0);
        check("t1_cnt_end", bus.fifo_cnt, 0);

        // 2: 40 DW split 16/16/8 under random backpressure
        for (int i = 0; i < 40; i++) push($urandom);
        commit(40);
        drain(40, 60, 1'b0, -1, 1'b0, 1'b0);
        check("t2_cnt_end", bus.fifo_cnt, 0);
        check("t2_seq_wrapped", exp_seq, 0);

        // 3: five short messages after reset, seq wraps 3 -> 0
        rst_n = 1'b0;
        #1;
        check_reset("t3_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        exp_seq = 0;
        mq.delete();
        done_seen = 0;
        for (int m = 0; m < 5; m++) begin
            for (int i = 0; i < 4; i++) push($urandom);
            commit(4);
            drain(4, 70, 1'b0, -1, 1'b0, 1'b0);
        end
        check("t3_done_pulses", done_seen, 5);

        // 4: bad commits
        for (int i = 0; i < 4; i++) push($urandom);
        commit(10);
        check("t4_len_gt_cnt", bus.err_cmd, 1);
        check("t4_no_busy", bus.busy, 0);
        check("t4_no_valid", bus.tx_valid, 0);
        step();
        check("t4_no_valid2", bus.tx_valid, 0);
        bus.err_clr = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_len = '0;
        step();
        bus.err_clr = 1'b0;
        bus.cmd_valid = 1'b0;
        check("t4_set_wins", bus.err_cmd, 1);
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        check("t4_clr", bus.err_cmd, 0);
        commit(0);
        check("t4_len0", bus.err_cmd, 1);
        check("t4_len0_valid", bus.tx_valid, 0);
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        check("t4_clr2", bus.err_cmd, 0);
        commit(4);
        drain(4, 100, 1'b1, -1, 1'b0, 1'b0);
        check("t4_err_kept", bus.err_cmd, 1);
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        check("t4_clr3", bus.err_cmd, 0);

        // 5: overflow, then push-at-full while draining
        check("t5_ovf_pre", bus.err_ovf, 0);
        for (int i = 0; i < 65; i++) push(DATA_W'(32'h100 + i));
        check("t5_cnt_full", bus.fifo_cnt, 64);
        check("t5_ovf", bus.err_ovf, 1);
        check("t5_model_cnt", mq.size(), 64);
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        check("t5_ovf_clr", bus.err_ovf, 0);
        commit(64);
        drain(64, 100, 1'b0, -1, 1'b0, 1'b1);
        check("t5_cnt_held", bus.fifo_cnt, mq.size());
        check("t5_no_ovf", bus.err_ovf, 0);
        bus.cmd_flush = 1'b1;
        step();
        bus.cmd_flush = 1'b0;
        mq.delete();
        check("t5_flush_cnt", bus.fifo_cnt, 0);
        check("t5_idle_no_abort", bus.tx_abort, 0);

        // 6: flush mid packet 2, seq resumes after last completed packet
        commit(0);
        exp_cmd = 1'b1;
        for (int i = 0; i < 40; i++) push($urandom);
        commit(40);
        drain(40, 80, 1'b0, 1, 1'b0, 1'b0);
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        exp_cmd = 1'b0;
        for (int i = 0; i < 4; i++) push($urandom);
        commit(4);
        drain(4, 100, 1'b0, -1, 1'b0, 1'b0);

        // same interruption by reset: seq restarts at 0
        for (int i = 0; i < 40; i++) push($urandom);
        commit(40);
        drain(40, 80, 1'b0, 1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) push($urandom);
        commit(4);
        drain(4, 100, 1'b0, -1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
